imm_gen: RTL and testbench
==========================

// Module: imm_gen
// PURPOSE
//   RV32I immediate generator for the decode stage of the rv32i core.
//   Takes instruction bits [31:7] and an immediate-format select from the control unit.
//   Extracts, reassembles and sign- or zero-extends the immediate to DWIDTH bits.
//   The result feeds the ALU B-mux, the branch/jump target adder and the LUI/AUIPC paths.
// PARAMETERS
//   DWIDTH  32  width of immediate output; legal values >= 32; bits above 31 replicate the extension bit
// PORTS
//   clk          input   1         clock; rising edge; used only with IMM_GEN_REG_OUT_EN
//   rst          input   1         synchronous, active-high reset; used only with IMM_GEN_REG_OUT_EN
//   instruction  input   25        instruction bits [31:7]; index 24 = instr[31]
//   ImmSel       input   3         immediate format select (encoding below)
//   immediate    output  DWIDTH    generated immediate
//   Interface rule: one clock; reset is synchronous and active-high.
// BEHAVIOUR
//   In the formulas below, i[n] denotes instr[n], which is instruction[n-7].
//   ImmSel encoding and required immediate:
//     0 I     : sext(i[31:20])
//     1 S     : sext({i[31:25], i[11:7]})
//     2 B     : sext({i[31], i[7], i[30:25], i[11:8], 1'b0})
//     3 U     : sext({i[31:12], 12'b0})
//     4 J     : sext({i[31], i[19:12], i[20], i[30:21], 1'b0})
//     5 SHAMT : zext(i[24:20])
//     6 ZIMM  : zext(i[19:15]); CSR uimm
//     7 NONE  : all zeros
//   Extension rules:
//     - sext replicates i[31] up to bit DWIDTH-1.
//     - zext fills with zeros up to bit DWIDTH-1.
//   Default build is purely combinational: zero latency, no state.
//   clk and rst are present but ignored in the default build.
//   X/Z on ImmSel must not propagate as a latch:
//     - the case statement is full; the default arm is NONE (zero).
//   No latches. No handshake.
// CONFIGURATION
//   IMM_GEN_REG_OUT_EN defined:
//     - immediate is registered on the rising edge of clk; latency is 1 cycle.
//     - rst=1 at an edge sets immediate to 0 on that edge, overriding new input.
//     - Reset mid-stream discards the in-flight value; the next edge after rst falls loads normally.
//   IMM_GEN_REG_OUT_EN undefined:
//     - combinational output as above; reset has no effect.
// STRUCTURE
//   Package imm_gen_pkg:
//     - localparams IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_SHAMT=5, IMM_ZIMM=6, IMM_NONE=7
//     - IMMSEL_W=3
//     - shared with the control unit.
//   Sub-module imm_gen_core (combinational extract/extend, DWIDTH-parameterised).
//   imm_gen wraps imm_gen_core plus the optional output register.
// TESTING
//   Each line gives instruction and ImmSel -> required immediate (DWIDTH=32).
//   1. 32'h00900093, ImmSel=0 -> 32'h00000009
//      32'hFFF00093, ImmSel=0 -> 32'hFFFFFFFF
//      32'h000102B3, ImmSel=0 -> 32'h00000000
//   2. 32'hFE512E23 (sw x5,-4(x2)), ImmSel=1 -> 32'hFFFFFFFC
//      32'hFE000CE3 (beq -8),       ImmSel=2 -> 32'hFFFFFFF8
//   3. 32'h123452B7 (lui), ImmSel=3 -> 32'h12345000
//      32'h001000EF (jal +2048), ImmSel=4 -> 32'h00000800
//   4. 32'h41F2D293 (srai x5,x5,31), ImmSel=5 -> 32'h0000001F
//      same instruction, ImmSel=6 -> 32'h00000005
//      same instruction, ImmSel=7 -> 32'h00000000
//   5. DWIDTH=64, 32'hFFF00093, ImmSel=0 -> 64'hFFFFFFFF_FFFFFFFF
//      DWIDTH=64, 32'h123452B7, ImmSel=3 -> 64'h00000000_12345000
//   6. With IMM_GEN_REG_OUT_EN:
//      - rst=1 for 2 edges -> immediate=0.
//      - Then apply 32'h00900093, ImmSel=0 -> immediate=9 one edge later, not before.
//      - Assert rst -> 0 at the next edge.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate-format select encodings shared by decode and control
package imm_gen_pkg;
  localparam int IMMSEL_W = 3;
  localparam logic [IMMSEL_W-1:0] IMM_I     = 3'd0;
  localparam logic [IMMSEL_W-1:0] IMM_S     = 3'd1;
  localparam logic [IMMSEL_W-1:0] IMM_B     = 3'd2;
  localparam logic [IMMSEL_W-1:0] IMM_U     = 3'd3;
  localparam logic [IMMSEL_W-1:0] IMM_J     = 3'd4;
  localparam logic [IMMSEL_W-1:0] IMM_SHAMT = 3'd5;
  localparam logic [IMMSEL_W-1:0] IMM_ZIMM  = 3'd6;
  localparam logic [IMMSEL_W-1:0] IMM_NONE  = 3'd7;
endpackage

// File: rtl/imm_gen_core.sv
// imm_gen_core: combinational RV32I immediate extract, reassemble and extend
module imm_gen_core
  import imm_gen_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [24:0]         instruction,
  input  logic [IMMSEL_W-1:0] ImmSel,
  output logic [DWIDTH-1:0]   immediate
);
  logic        w_s;
  logic [31:0] w_imm;
  logic        w_ext;
  assign w_s = instruction[24];
  // instruction[k] holds instr[k+7]; each arm rebuilds one format's 32-bit value and its fill bit
  always_comb begin
    w_imm = '0;
    w_ext = 1'b0;
    case (ImmSel)
      IMM_I:     begin w_imm = {{20{w_s}}, instruction[24:13]}; w_ext = w_s; end
      IMM_S:     begin w_imm = {{20{w_s}}, instruction[24:18], instruction[4:0]}; w_ext = w_s; end
      IMM_B:     begin w_imm = {{19{w_s}}, w_s, instruction[0], instruction[23:18], instruction[4:1], 1'b0}; w_ext = w_s; end
      IMM_U:     begin w_imm = {instruction[24:5], 12'b0}; w_ext = w_s; end
      IMM_J:     begin w_imm = {{11{w_s}}, w_s, instruction[12:5], instruction[13], instruction[23:14], 1'b0}; w_ext = w_s; end
      IMM_SHAMT: w_imm = {27'b0, instruction[17:13]};
      IMM_ZIMM:  w_imm = {27'b0, instruction[12:8]};
      default:   w_imm = '0;
    endcase
  end
  // bits above 31 replicate the fill bit
  always_comb begin
    immediate = {DWIDTH{w_ext}};
    immediate[31:0] = w_imm;
  end
endmodule

// File: rtl/imm_gen.sv
// imm_gen: RV32I immediate generator; IMM_GEN_REG_OUT_EN adds a 1-cycle output register
module imm_gen
  import imm_gen_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [24:0]         instruction,
  input  logic [IMMSEL_W-1:0] ImmSel,
  output logic [DWIDTH-1:0]   immediate
);
  logic [DWIDTH-1:0] w_imm;
  imm_gen_core #(.DWIDTH(DWIDTH)) u_core (
    .instruction(instruction),
    .ImmSel     (ImmSel),
    .immediate  (w_imm)
  );
`ifdef IMM_GEN_REG_OUT_EN
  logic [DWIDTH-1:0] r_imm;
  // register the immediate; reset wins over the incoming value
  always_ff @(posedge clk) begin
    if (rst) r_imm <= '0;
    else     r_imm <= w_imm;
  end
  assign immediate = r_imm;
`else
  logic w_unused;
  assign w_unused  = clk ^ rst;
  assign immediate = w_imm;
`endif
endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: vector table, random model comparison and reset/latency sequences for imm_gen
module tb_imm_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = 32'hFFF00093;
  logic [2:0]  sel = 3'd0;
  logic [31:0] imm32;
  logic [63:0] imm64;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen #(.DWIDTH(32)) dut32 (.clk(clk), .rst(rst), .instruction(ins[31:7]), .ImmSel(sel), .immediate(imm32));
  imm_gen #(.DWIDTH(64)) dut64 (.clk(clk), .rst(rst), .instruction(ins[31:7]), .ImmSel(sel), .immediate(imm64));

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  sel;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [63:0] ref_imm(input logic [31:0] x, input logic [2:0] s);
    longint v;
    longint neg;
    neg = x[31] ? 64'sd1 : 64'sd0;
    case (s)
      3'd0: v = longint'(x[31:20]) - neg * 4096;
      3'd1: v = longint'(x[31:25]) * 32 + longint'(x[11:7]) - neg * 4096;
      3'd2: v = longint'(x[7]) * 2048 + longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2 - neg * 4096;
      3'd3: v = longint'(x[31:12]) * 4096 - neg * 64'sd4294967296;
      3'd4: v = longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048 + longint'(x[30:21]) * 2 - neg * 1048576;
      3'd5: v = longint'(x[24:20]);
      3'd6: v = longint'(x[19:15]);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] x, input logic [2:0] s);
    ins = x;
    sel = s;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];
  logic [63:0] e;

  initial begin
    tbl[0] = '{32'h00900093, 3'd0, 32'h00000009};
    tbl[1] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF};
    tbl[2] = '{32'h000102B3, 3'd0, 32'h00000000};
    tbl[3] = '{32'hFE512E23, 3'd1, 32'hFFFFFFFC};
    tbl[4] = '{32'hFE000CE3, 3'd2, 32'hFFFFFFF8};
    tbl[5] = '{32'h123452B7, 3'd3, 32'h12345000};
    tbl[6] = '{32'h001000EF, 3'd4, 32'h00000800};
    tbl[7] = '{32'h41F2D293, 3'd5, 32'h0000001F};
    tbl[8] = '{32'h41F2D293, 3'd6, 32'h00000005};
    tbl[9] = '{32'h41F2D293, 3'd7, 32'h00000000};
    repeat (2) @(posedge clk);
    #1;
`ifdef IMM_GEN_REG_OUT_EN
    chk("reset32", {32'h0, imm32}, 64'h0);
    chk("reset64", imm64, 64'h0);
`else
    chk("reset32_ignored", {32'h0, imm32}, 64'h0000_0000_FFFF_FFFF);
    chk("reset64_ignored", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      apply(tbl[k].ins, tbl[k].sel);
      chk($sformatf("vec%0d", k), {32'h0, imm32}, {32'h0, tbl[k].exp});
    end
    apply(32'hFFF00093, 3'd0);
    chk("w64_i_neg", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    apply(32'h123452B7, 3'd3);
    chk("w64_u_pos", imm64, 64'h0000_0000_1234_5000);
    apply(32'h800002B7, 3'd3);
    chk("w64_u_neg", imm64, 64'hFFFF_FFFF_8000_0000);
    apply(32'h80000093, 3'd5);
    chk("w64_shamt_zext", imm64, 64'h0);
    for (int k = 0; k < 300; k++) begin
      logic [31:0] x;
      logic [2:0]  s;
      x = $urandom;
      s = 3'($urandom_range(0, 7));
      apply(x, s);
      e = ref_imm(x, s);
      chk($sformatf("rnd32 ins=%h sel=%0d", x, s), {32'h0, imm32}, {32'h0, e[31:0]});
      chk($sformatf("rnd64 ins=%h sel=%0d", x, s), imm64, e);
    end
    apply(32'h000102B3, 3'd7);
    ins = 32'h00900093;
    sel = 3'd0;
    #1;
`ifdef IMM_GEN_REG_OUT_EN
    chk("latency_not_before", {32'h0, imm32}, 64'h0);
    @(posedge clk);
    #1;
    chk("latency_one_edge", {32'h0, imm32}, 64'h9);
    rst = 1'b1;
    ins = 32'hFFF00093;
    @(posedge clk);
    #1;
    chk("midstream_reset32", {32'h0, imm32}, 64'h0);
    chk("midstream_reset64", imm64, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("after_reset_load", {32'h0, imm32}, 64'h0000_0000_FFFF_FFFF);
`else
    chk("comb_zero_latency", {32'h0, imm32}, 64'h9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("comb_reset_ignored", {32'h0, imm32}, 64'h9);
    rst = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
